// File: rtl/memory_io_responder.sv
// Data-memory responder: decodes CPU loads/stores into a word RAM and a small
// memory-mapped I/O page, stalling the CPU for one cycle on RAM loads.
module memory_io_responder #(
  parameter int          Dbits     = 32,
  parameter int          Nloc      = 1024,
  parameter logic [31:0] DMEM_BASE = 32'h1001_0000,
  parameter logic [31:0] IO_BASE   = 32'h1003_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      mem_addr,
  input  logic             mem_wr,
  input  logic             mem_rd,
  input  logic [Dbits-1:0] mem_writedata,
  output logic [Dbits-1:0] mem_readdata,
  output logic             cpu_enable,
  input  logic             key_valid,
  input  logic [7:0]       key_code,
  input  logic [31:0]      accel,
  output logic [31:0]      sound_period,
  output logic [15:0]      lights
);

  localparam int AW = $clog2(Nloc);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t           state_q, state_d;
  logic [Dbits-1:0] ram [Nloc];
  logic [Dbits-1:0] ram_q;
  logic             ram_rd_en;
  logic [7:0]       key_code_q, key_code_d;
  logic             pending_q, pending_d;
  logic [7:0]       ovrn_q, ovrn_d;
  logic [31:0]      sound_q, sound_d;
  logic [15:0]      lights_q, lights_d;

  logic [31:0]      dmem_off;
  logic             dmem_hit, io_hit;
  logic [2:0]       io_off;
  logic [AW-1:0]    ram_idx;
  logic             wr_fx, rd_fx, key_rd, ovrn_rd, overrun;
  logic [31:0]      io_rdata;

  assign dmem_off = mem_addr - DMEM_BASE;
  assign dmem_hit = (mem_addr >= DMEM_BASE) && (dmem_off < 32'(4 * Nloc));
  assign ram_idx  = dmem_off[AW+1:2];
  assign io_hit   = (mem_addr[31:5] == IO_BASE[31:5]);
  assign io_off   = mem_addr[4:2];

  always_comb begin
    state_d    = state_q;
    cpu_enable = 1'b1;
    ram_rd_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_rd && dmem_hit) begin
          cpu_enable = 1'b0;
          ram_rd_en  = 1'b1;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The CPU must never be held while reset is asserted.
    if (!reset_n) begin
      cpu_enable = 1'b1;
      ram_rd_en  = 1'b0;
    end
  end

  assign wr_fx   = cpu_enable && mem_wr && reset_n;
  assign rd_fx   = cpu_enable && mem_rd;
  assign key_rd  = rd_fx && io_hit && (io_off == 3'd0);
  assign ovrn_rd = rd_fx && io_hit && (io_off == 3'd4);
  assign overrun = key_valid && pending_q && !key_rd;

  always_comb begin
    key_code_d = key_code_q;
    pending_d  = pending_q;
    ovrn_d     = ovrn_q;
    sound_d    = sound_q;
    lights_d   = lights_q;
    if (key_valid) begin
      key_code_d = key_code;
      pending_d  = 1'b1;
    end else if (key_rd) begin
      pending_d = 1'b0;
    end
    // A clearing read races a fresh overrun: the overrun survives as a count of one.
    if (ovrn_rd)
      ovrn_d = overrun ? 8'd1 : 8'd0;
    else if (overrun && ovrn_q != 8'hFF)
      ovrn_d = ovrn_q + 8'd1;
    if (wr_fx && io_hit && io_off == 3'd2) sound_d  = mem_writedata[31:0];
    if (wr_fx && io_hit && io_off == 3'd3) lights_d = mem_writedata[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      key_code_q <= '0;
      pending_q  <= 1'b0;
      ovrn_q     <= '0;
      sound_q    <= '0;
      lights_q   <= '0;
    end else begin
      state_q    <= state_d;
      key_code_q <= key_code_d;
      pending_q  <= pending_d;
      ovrn_q     <= ovrn_d;
      sound_q    <= sound_d;
      lights_q   <= lights_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fx && dmem_hit) ram[ram_idx] <= mem_writedata;
    if (ram_rd_en) ram_q <= ram[ram_idx];
  end

  always_comb begin
    io_rdata = '0;
    case (io_off)
      3'd0:    io_rdata = {23'b0, pending_q, key_code_q};
      3'd1:    io_rdata = accel;
      3'd2:    io_rdata = sound_q;
      3'd3:    io_rdata = {16'b0, lights_q};
      3'd4:    io_rdata = {24'b0, ovrn_q};
      default: io_rdata = '0;
    endcase
  end

  always_comb begin
    mem_readdata = '0;
    if (reset_n && mem_rd) begin
      if (state_q == RD_WAIT)
        mem_readdata = ram_q;
      else if (io_hit)
        mem_readdata = Dbits'(io_rdata);
    end
  end

  assign sound_period = sound_q;
  assign lights       = lights_q;

endmodule

// File: tb/tb_memory_io_responder.sv
// Scoreboarded bench for memory_io_responder: directed scenarios plus random
// loads/stores, checked against a behavioural memory/I-O model.
module tb_memory_io_responder;

  localparam logic [31:0] DB   = 32'h1001_0000;
  localparam logic [31:0] IO   = 32'h1003_0000;
  localparam int          NLOC = 1024;
  localparam int          NOP = 0, LW = 1, SW = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem_addr, mem_writedata, mem_readdata, accel, sound_period;
  logic        mem_wr, mem_rd, cpu_enable, key_valid;
  logic [7:0]  key_code;
  logic [15:0] lights;

  memory_io_responder #(.Dbits(32), .Nloc(NLOC), .DMEM_BASE(DB), .IO_BASE(IO)) dut (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .cpu_enable(cpu_enable),
    .key_valid(key_valid), .key_code(key_code), .accel(accel),
    .sound_period(sound_period), .lights(lights)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          stalls;
    bit          is_rd;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          mon_stalls = 0;

  logic [31:0] mem_m [int];
  int          widx[$];
  bit          m_pend;
  logic [7:0]  m_code, m_ovrn;
  logic [31:0] m_sound;
  logic [15:0] m_lights;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_dmem(input logic [31:0] a);
    return (a >= DB) && (a < DB + 32'(4 * NLOC));
  endfunction

  function automatic bit in_io(input logic [31:0] a);
    return (a >> 5) == (IO >> 5);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    if (in_dmem(a)) begin
      idx = int'((a - DB) >> 2);
      return mem_m.exists(idx) ? mem_m[idx] : 32'h0;
    end
    if (in_io(a)) begin
      case (a[4:2])
        3'd0:    return (m_pend ? 32'h100 : 32'h0) | 32'(m_code);
        3'd1:    return accel;
        3'd2:    return m_sound;
        3'd3:    return 32'(m_lights);
        3'd4:    return 32'(m_ovrn);
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    int idx;
    if (in_dmem(a)) begin
      idx = int'((a - DB) >> 2);
      mem_m[idx] = d;
      widx.push_back(idx);
    end else if (in_io(a)) begin
      if (a[4:2] == 3'd2) m_sound = d;
      if (a[4:2] == 3'd3) m_lights = d[15:0];
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_code = 8'h0; m_ovrn = 8'h0; m_sound = 32'h0; m_lights = 16'h0;
  endtask

  // One CPU instruction; entered and left just after a rising edge.
  task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] wd,
                        input bit kv, input logic [7:0] kc);
    exp_t e;
    int   n;
    bit   en, key_rd, ovrn_rd, ovr;
    if (op != NOP) begin
      e.is_rd  = (op == LW);
      e.data   = (op == LW) ? model_read(addr) : 32'h0;
      e.stalls = (op == LW && in_dmem(addr)) ? 1 : 0;
      e.name   = (op == LW) ? "load" : "store";
      sb.push_back(e);
    end
    mem_addr = addr; mem_rd = (op == LW); mem_wr = (op == SW);
    mem_writedata = wd; key_valid = kv; key_code = kc;
    n = 0;
    do begin
      @(negedge clk);
      en = cpu_enable;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      n++;
    end while (!en && n < 4);
    if (!en) chk("stall_bound", 32'(en), 32'd1);
    key_rd  = (op == LW) && in_io(addr) && addr[4:2] == 3'd0;
    ovrn_rd = (op == LW) && in_io(addr) && addr[4:2] == 3'd4;
    ovr     = kv && m_pend && !key_rd;
    if (kv) begin m_code = kc; m_pend = 1'b1; end
    else if (key_rd) m_pend = 1'b0;
    if (ovrn_rd) m_ovrn = ovr ? 8'd1 : 8'd0;
    else if (ovr && m_ovrn != 8'hFF) m_ovrn++;
    if (op == SW) model_write(addr, wd);
    mem_rd = 1'b0; mem_wr = 1'b0;
    chk("lights", 32'(lights), 32'(m_lights));
    chk("sound", sound_period, m_sound);
  endtask

  // Monitor: a transfer completes on the cycle the DUT lets the CPU advance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) mon_stalls = 0;
      else if (mem_rd || mem_wr) begin
        if (!cpu_enable) mon_stalls++;
        else begin
          if (sb.size() == 0) chk("sb_size", 32'(sb.size()), 32'd1);
          else begin
            e = sb.pop_front();
            chk({e.name, "_stalls"}, 32'(mon_stalls), 32'(e.stalls));
            if (e.is_rd) chk({e.name, "_data"}, mem_readdata, e.data);
          end
          mon_stalls = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] unm [5];
  logic [31:0] a;
  int          op, cat;

  initial begin
    unm = '{32'h0, DB - 32'd4, DB + 32'(4 * NLOC), IO + 32'h20, IO - 32'd4};
    model_reset();
    reset_n = 1'b0; mem_addr = IO; mem_rd = 1'b1; mem_wr = 1'b0; mem_writedata = '0;
    key_valid = 1'b0; key_code = '0; accel = 32'h0012_FFF0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_enable", 32'(cpu_enable), 32'd1);
    chk("rst_readdata", mem_readdata, 32'h0);
    chk("rst_lights", 32'(lights), 32'h0);
    chk("rst_sound", sound_period, 32'h0);
    mem_rd = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // RAM store/load round trip, combinational accel read
    run_op(SW, 32'h1001_0010, 32'hDEAD_BEEF, 0, 8'h0);
    run_op(LW, 32'h1001_0010, 32'h0, 0, 8'h0);
    run_op(LW, 32'h1003_0004, 32'h0, 0, 8'h0);
    // key latch and pending clear
    run_op(NOP, 32'h0, 32'h0, 1, 8'h41);
    run_op(LW, IO, 32'h0, 0, 8'h0);
    run_op(LW, IO, 32'h0, 0, 8'h0);
    // overrun counting, clear, saturation
    for (int i = 0; i < 3; i++) run_op(NOP, 32'h0, 32'h0, 1, 8'(8'h50 + i));
    run_op(LW, IO + 32'h10, 32'h0, 0, 8'h0);
    run_op(LW, IO + 32'h10, 32'h0, 0, 8'h0);
    for (int i = 0; i < 260; i++) run_op(NOP, 32'h0, 32'h0, 1, 8'(i));
    run_op(LW, IO + 32'h10, 32'h0, 0, 8'h0);
    // key arriving on the same edge as a KEY read
    run_op(LW, IO, 32'h0, 1, 8'h5A);
    run_op(LW, IO, 32'h0, 0, 8'h0);
    run_op(LW, IO + 32'h10, 32'h0, 0, 8'h0);
    // overrun arriving on the same edge as an OVRN read
    run_op(NOP, 32'h0, 32'h0, 1, 8'h11);
    run_op(LW, IO + 32'h10, 32'h0, 1, 8'h22);
    run_op(LW, IO + 32'h10, 32'h0, 0, 8'h0);
    // read-only registers ignore stores
    run_op(SW, IO, 32'hFFFF_FFFF, 0, 8'h0);
    run_op(SW, IO + 32'h10, 32'hFFFF_FFFF, 0, 8'h0);
    run_op(LW, IO, 32'h0, 0, 8'h0);

    // reset while a RAM load sits in RD_WAIT
    run_op(SW, IO + 32'hC, 32'h0000_1234, 0, 8'h0);
    run_op(SW, IO + 32'h8, 32'h0000_0BAD, 0, 8'h0);
    mem_addr = 32'h1001_0010; mem_rd = 1'b1;
    @(negedge clk);
    chk("pre_rst_stall", 32'(cpu_enable), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    chk("in_rst_cpu_enable", 32'(cpu_enable), 32'd1);
    chk("in_rst_readdata", mem_readdata, 32'h0);
    chk("in_rst_lights", 32'(lights), 32'h0);
    chk("in_rst_sound", sound_period, 32'h0);
    mem_rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(LW, 32'h1001_0010, 32'h0, 0, 8'h0);
    run_op(LW, 32'h0, 32'h0, 0, 8'h0);
    run_op(SW, 32'h0, 32'h1234_5678, 0, 8'h0);
    run_op(LW, IO, 32'h0, 0, 8'h0);

    // boundary words of the RAM
    run_op(SW, DB, 32'hA5A5_0001, 0, 8'h0);
    run_op(SW, DB + 32'(4 * (NLOC - 1)), 32'h5A5A_0002, 0, 8'h0);
    run_op(LW, DB + 32'(4 * (NLOC - 1)), 32'h0, 0, 8'h0);
    run_op(LW, DB + 32'(4 * NLOC), 32'h0, 0, 8'h0);

    for (int i = 0; i < 400; i++) begin
      op    = int'($urandom_range(1, 2));
      cat   = int'($urandom_range(0, 3));
      accel = $urandom();
      if (cat == 0 && op == SW)
        a = DB + 32'(4 * (($urandom_range(0, 7) == 0) ? NLOC - 1 : int'($urandom_range(0, 63))));
      else if (cat == 0 && widx.size() > 0)
        a = DB + 32'(4 * widx[$urandom_range(0, widx.size() - 1)]);
      else if (cat == 2)
        a = unm[$urandom_range(0, 4)];
      else
        a = IO + 32'(4 * $urandom_range(0, 7));
      a = a | 32'($urandom_range(0, 3));
      run_op(op, a, $urandom(), ($urandom_range(0, 3) == 0), 8'($urandom()));
    end

    repeat (4) @(posedge clk);
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
